combo_lock_param: RTL and testbench

COMBO_LOCK_PARAM -- requirements
Module: combo_lock_param

---
 rtl/combo_lock_param_pkg.sv | 25 ++
 rtl/combo_lock_param_button_edge.sv | 29 ++
 rtl/combo_lock_param.sv | 214 +++++++++++++++++++++
 tb/tb_combo_lock_param.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_lock_param_pkg.sv
// Shared definitions for the parameterised combination lock.
// Contents:
//   lock_state_t  - state encoding of the lock controller
//   NUM_BUTTONS   - number of digit buttons (0 and 1)
//   BTN_ZERO/ONE  - bit positions of each button in the button vectors
//   width_for()   - register width needed to hold values 0..max_value
package combo_lock_param_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_PROGRAM  = 2'd2,
    ST_LOCKOUT  = 2'd3
  } lock_state_t;

  localparam int NUM_BUTTONS = 2;
  localparam int BTN_ZERO    = 0;
  localparam int BTN_ONE     = 1;

  // $clog2(1) is 0, so small ranges are clamped to a 1-bit register.
  function automatic int width_for(input int max_value);
    return (max_value < 2) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/combo_lock_param_button_edge.sv
// Rising-edge detector for one already-synchronous button level.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset, clears the edge history
//   level - button level
//   rise  - high in the cycle where level is high and was low the cycle before
module button_edge
  import combo_lock_param_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= level;
    end
  end

  // A held button produces exactly one event: prev_reg is high afterwards.
  assign rise = level & ~prev_reg;

endmodule

// File: rtl/combo_lock_param.sv
// Two-button combination lock with lockout after repeated failures and
// in-field reprogramming of the code while unlocked.
// Ports:
//   CLK            - clock, rising edge
//   RESET_Button   - synchronous active-low reset
//   ZERO_Button    - digit-0 button level (synchronous to CLK)
//   ONE_Button     - digit-1 button level (synchronous to CLK)
//   PROG_Enable    - request to reprogram the code while unlocked
//   UNLOCK_Output  - high while unlocked or programming
//   LOCKOUT_Output - high during lockout
//   ERROR_Pulse    - one-cycle pulse on a rejected entry
//   DIGIT_Count    - digits entered so far in the current entry
module combo_lock_param
  import combo_lock_param_pkg::*;
#(
  parameter int                 CODE_LEN       = 6,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE  = 6'b010110,
  parameter int                 MAX_TRIES      = 3,
  parameter int                 LOCKOUT_CYCLES = 16,
  parameter int                 UNLOCK_CYCLES  = 8
) (
  input  logic                             CLK,
  input  logic                             RESET_Button,
  input  logic                             ZERO_Button,
  input  logic                             ONE_Button,
  input  logic                             PROG_Enable,
  output logic                             UNLOCK_Output,
  output logic                             LOCKOUT_Output,
  output logic                             ERROR_Pulse,
  output logic [$clog2(CODE_LEN+1)-1:0]    DIGIT_Count
);

  localparam int CNT_W     = $clog2(CODE_LEN + 1);
  localparam int FAIL_W    = width_for(MAX_TRIES);
  localparam int TIMER_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
  localparam int TIMER_W   = width_for(TIMER_MAX);

  // ---------------------------------------------------------------------
  // Button edge detection, one detector per button
  // ---------------------------------------------------------------------
  logic [NUM_BUTTONS-1:0] btn_level;
  logic [NUM_BUTTONS-1:0] btn_rise;

  assign btn_level[BTN_ZERO] = ZERO_Button;
  assign btn_level[BTN_ONE]  = ONE_Button;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      button_edge u_edge (
        .clk   (CLK),
        .rst_n (RESET_Button),
        .level (btn_level[gi]),
        .rise  (btn_rise[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  lock_state_t         state_reg;
  logic [CODE_LEN-1:0] code_reg;
  // Only the digits before the current one are kept; the newest digit
  // comes straight from the edge detectors when the entry completes.
  logic [CODE_LEN-2:0] entry_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [FAIL_W-1:0]   fail_reg;
  logic [TIMER_W-1:0]  timer_reg;
  logic                bad_reg;
  logic                unlock_reg;
  logic                lockout_reg;
  logic                error_reg;

  // ---------------------------------------------------------------------
  // Entry datapath
  // ---------------------------------------------------------------------
  logic                digit_event;
  logic                bad_digit;
  logic                digit_bit;
  logic                last_digit;
  logic                code_match;
  logic                fail_limit;
  logic                unlock_done;
  logic                lockout_done;
  logic [CODE_LEN-1:0] entry_shifted;
  logic [FAIL_W-1:0]   fail_inc;

  assign digit_event   = |btn_rise;
  assign bad_digit     = &btn_rise;
  assign digit_bit     = btn_rise[BTN_ONE] & ~btn_rise[BTN_ZERO];
  assign entry_shifted = {entry_reg, digit_bit};
  assign last_digit    = (count_reg == CNT_W'(CODE_LEN - 1));
  // A bad digit anywhere in the entry forces a mismatch regardless of bits.
  assign code_match    = (entry_shifted == code_reg) && !bad_reg && !bad_digit;
  assign fail_inc      = fail_reg + FAIL_W'(1);
  assign fail_limit    = (fail_inc >= FAIL_W'(MAX_TRIES));
  assign unlock_done   = (timer_reg == TIMER_W'(UNLOCK_CYCLES - 1));
  assign lockout_done  = (timer_reg == TIMER_W'(LOCKOUT_CYCLES - 1));

  // ---------------------------------------------------------------------
  // Controller with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!RESET_Button) begin
      state_reg   <= ST_LOCKED;
      code_reg    <= DEFAULT_CODE;
      entry_reg   <= '0;
      count_reg   <= '0;
      fail_reg    <= '0;
      timer_reg   <= '0;
      bad_reg     <= 1'b0;
      unlock_reg  <= 1'b0;
      lockout_reg <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      error_reg <= 1'b0;
      case (state_reg)
        ST_LOCKED: begin
          if (digit_event) begin
            entry_reg <= entry_shifted[CODE_LEN-2:0];
            if (last_digit) begin
              count_reg <= '0;
              bad_reg   <= 1'b0;
              if (code_match) begin
                state_reg  <= ST_UNLOCKED;
                unlock_reg <= 1'b1;
                fail_reg   <= '0;
                timer_reg  <= '0;
              end else begin
                error_reg <= 1'b1;
                fail_reg  <= fail_inc;
                if (fail_limit) begin
                  state_reg   <= ST_LOCKOUT;
                  lockout_reg <= 1'b1;
                  timer_reg   <= '0;
                end
              end
            end else begin
              count_reg <= count_reg + CNT_W'(1);
              if (bad_digit) begin
                bad_reg <= 1'b1;
              end
            end
          end
        end

        ST_UNLOCKED: begin
          // Programming request wins over timer expiry; the timer is
          // simply not advanced while programming.
          if (PROG_Enable) begin
            state_reg <= ST_PROGRAM;
            count_reg <= '0;
          end else if (unlock_done) begin
            state_reg  <= ST_LOCKED;
            unlock_reg <= 1'b0;
            timer_reg  <= '0;
            count_reg  <= '0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end

        ST_PROGRAM: begin
          if (!PROG_Enable || bad_digit) begin
            // Abort: code register is left untouched.
            state_reg  <= ST_LOCKED;
            unlock_reg <= 1'b0;
            timer_reg  <= '0;
            count_reg  <= '0;
          end else if (digit_event) begin
            entry_reg <= entry_shifted[CODE_LEN-2:0];
            if (last_digit) begin
              code_reg   <= entry_shifted;
              state_reg  <= ST_LOCKED;
              unlock_reg <= 1'b0;
              timer_reg  <= '0;
              count_reg  <= '0;
            end else begin
              count_reg <= count_reg + CNT_W'(1);
            end
          end
        end

        ST_LOCKOUT: begin
          if (lockout_done) begin
            state_reg   <= ST_LOCKED;
            lockout_reg <= 1'b0;
            fail_reg    <= '0;
            timer_reg   <= '0;
            count_reg   <= '0;
            bad_reg     <= 1'b0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end

        default: begin
          state_reg   <= ST_LOCKED;
          unlock_reg  <= 1'b0;
          lockout_reg <= 1'b0;
          count_reg   <= '0;
          timer_reg   <= '0;
        end
      endcase
    end
  end

  assign UNLOCK_Output  = unlock_reg;
  assign LOCKOUT_Output = lockout_reg;
  assign ERROR_Pulse    = error_reg;
  assign DIGIT_Count    = count_reg;

endmodule

// File: tb/tb_combo_lock_param.sv
module tb_combo_lock_param;

  logic       clk = 1'b0;
  logic       reset_button = 1'b0;
  logic       zero_btn = 1'b0;
  logic       one_btn = 1'b0;
  logic       prog_en = 1'b0;
  logic       unlock_out;
  logic       lockout_out;
  logic       error_out;
  logic [2:0] digit_count;

  int total = 0;
  int bad = 0;

  combo_lock_param #(
    .CODE_LEN       (6),
    .DEFAULT_CODE   (6'b010110),
    .MAX_TRIES      (3),
    .LOCKOUT_CYCLES (16),
    .UNLOCK_CYCLES  (8)
  ) dut (
    .CLK            (clk),
    .RESET_Button   (reset_button),
    .ZERO_Button    (zero_btn),
    .ONE_Button     (one_btn),
    .PROG_Enable    (prog_en),
    .UNLOCK_Output  (unlock_out),
    .LOCKOUT_Output (lockout_out),
    .ERROR_Pulse    (error_out),
    .DIGIT_Count    (digit_count)
  );

  always #5 clk = ~clk;

  // Stimulus helpers: called at a falling edge, return at the falling edge
  // right after the digit's event edge.
  task automatic press(input logic d);
    if (d) one_btn = 1'b1;
    else   zero_btn = 1'b1;
    @(negedge clk);
    one_btn  = 1'b0;
    zero_btn = 1'b0;
  endtask

  task automatic press_both();
    one_btn  = 1'b1;
    zero_btn = 1'b1;
    @(negedge clk);
    one_btn  = 1'b0;
    zero_btn = 1'b0;
  endtask

  task automatic enter_code(input logic [5:0] code, input int gap);
    for (int i = 0; i < 6; i++) begin
      press(code[5-i]);
      if (i < 5) repeat (gap - 1) @(negedge clk);
    end
    $display("entered code %b", code);
  endtask

  task automatic test_reset();
    reset_button = 1'b0;
    repeat (2) @(negedge clk);
    reset_button = 1'b1;
    @(negedge clk);
    total++; if (unlock_out !== 1'b0) begin bad++; $display("FAIL reset_unlock got=%b want=0", unlock_out); end
    total++; if (lockout_out !== 1'b0) begin bad++; $display("FAIL reset_lockout got=%b want=0", lockout_out); end
    total++; if (error_out !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", error_out); end
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", digit_count); end
    $display("test_reset done");
  endtask

  task automatic test_unlock();
    logic [5:0] code;
    int hi;
    code = 6'b010110;
    for (int i = 0; i < 6; i++) begin
      press(code[5-i]);
      if (i < 5) begin
        total++;
        if (digit_count !== 3'(i + 1)) begin
          bad++; $display("FAIL unlock_count digit=%0d got=%0d want=%0d", i, digit_count, i + 1);
        end
        repeat (4) @(negedge clk);
      end
    end
    total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL unlock_rise got=%b want=1", unlock_out); end
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL unlock_count_clear got=%0d want=0", digit_count); end
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      if (unlock_out) hi++;
      @(negedge clk);
    end
    total++; if (hi != 8) begin bad++; $display("FAIL unlock_hold got=%0d want=8", hi); end
    total++; if (unlock_out !== 1'b0) begin bad++; $display("FAIL unlock_fall got=%b want=0", unlock_out); end
    $display("test_unlock done: hold=%0d", hi);
  endtask

  task automatic test_lockout();
    logic [5:0] code;
    int lo;
    for (int t = 0; t < 3; t++) begin
      enter_code(6'b111111, 2);
      total++; if (error_out !== 1'b1) begin bad++; $display("FAIL lockout_error try=%0d got=%b want=1", t, error_out); end
      total++; if (unlock_out !== 1'b0) begin bad++; $display("FAIL lockout_no_unlock try=%0d got=%b want=0", t, unlock_out); end
      total++;
      if (lockout_out !== (t == 2)) begin
        bad++; $display("FAIL lockout_level try=%0d got=%b want=%b", t, lockout_out, (t == 2));
      end
      if (t < 2) begin
        @(negedge clk);
        total++; if (error_out !== 1'b0) begin bad++; $display("FAIL error_width try=%0d got=%b want=0", t, error_out); end
        @(negedge clk);
      end
    end
    // Present the correct code during lockout while measuring its length.
    code = 6'b010110;
    lo = 0;
    for (int c = 0; c < 25; c++) begin
      if (lockout_out) lo++;
      if (unlock_out !== 1'b0) begin
        total++; bad++; $display("FAIL lockout_unlocked cycle=%0d got=1 want=0", c);
      end
      if (c < 12 && (c % 2) == 0) begin
        if (code[5 - c/2]) one_btn = 1'b1;
        else               zero_btn = 1'b1;
      end else begin
        one_btn = 1'b0; zero_btn = 1'b0;
      end
      @(negedge clk);
    end
    total++; if (lo != 16) begin bad++; $display("FAIL lockout_len got=%0d want=16", lo); end
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL lockout_count got=%0d want=0", digit_count); end
    enter_code(6'b010110, 2);
    total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL lockout_after got=%b want=1", unlock_out); end
    repeat (10) @(negedge clk);
    $display("test_lockout done: len=%0d", lo);
  endtask

  task automatic test_bad_digit();
    press(1'b0); @(negedge clk);
    press(1'b1); @(negedge clk);
    press_both();
    total++; if (digit_count !== 3'd3) begin bad++; $display("FAIL bad_digit_count got=%0d want=3", digit_count); end
    @(negedge clk);
    press(1'b1); @(negedge clk);
    press(1'b1); @(negedge clk);
    press(1'b0);
    total++; if (error_out !== 1'b1) begin bad++; $display("FAIL bad_digit_error got=%b want=1", error_out); end
    total++; if (unlock_out !== 1'b0) begin bad++; $display("FAIL bad_digit_unlock got=%b want=0", unlock_out); end
    repeat (2) @(negedge clk);
    $display("test_bad_digit done");
  endtask

  task automatic test_program();
    logic [5:0] newc;
    newc = 6'b110011;
    enter_code(6'b010110, 2);
    total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL prog_unlock got=%b want=1", unlock_out); end
    prog_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      press(newc[5-i]);
      if (i == 4) begin
        total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL prog_hold got=%b want=1", unlock_out); end
        total++; if (digit_count !== 3'd5) begin bad++; $display("FAIL prog_count got=%0d want=5", digit_count); end
      end
      if (i < 5) @(negedge clk);
    end
    total++; if (unlock_out !== 1'b0) begin bad++; $display("FAIL prog_done got=%b want=0", unlock_out); end
    prog_en = 1'b0;
    @(negedge clk);
    enter_code(6'b010110, 2);
    total++; if (error_out !== 1'b1) begin bad++; $display("FAIL prog_old_code got=%b want=1", error_out); end
    repeat (2) @(negedge clk);
    enter_code(6'b110011, 2);
    total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL prog_new_code got=%b want=1", unlock_out); end
    repeat (10) @(negedge clk);
    $display("test_program done");
  endtask

  task automatic test_prog_abort();
    enter_code(6'b110011, 2);
    prog_en = 1'b1;
    @(negedge clk);
    press(1'b0); @(negedge clk);
    press(1'b0);
    total++; if (digit_count !== 3'd2) begin bad++; $display("FAIL abort_count got=%0d want=2", digit_count); end
    prog_en = 1'b0;
    @(negedge clk);
    total++; if (unlock_out !== 1'b0) begin bad++; $display("FAIL abort_lock got=%b want=0", unlock_out); end
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL abort_count_clear got=%0d want=0", digit_count); end
    enter_code(6'b110011, 2);
    total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL abort_code_kept got=%b want=1", unlock_out); end
    repeat (10) @(negedge clk);
    $display("test_prog_abort done");
  endtask

  task automatic test_reset_mid_entry();
    press(1'b0); @(negedge clk);
    press(1'b1); @(negedge clk);
    press(1'b0); @(negedge clk);
    press(1'b1);
    total++; if (digit_count !== 3'd4) begin bad++; $display("FAIL mid_count got=%0d want=4", digit_count); end
    reset_button = 1'b0;
    @(negedge clk);
    reset_button = 1'b1;
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL mid_reset_count got=%0d want=0", digit_count); end
    @(negedge clk);
    enter_code(6'b010110, 2);
    total++; if (unlock_out !== 1'b1) begin bad++; $display("FAIL mid_default_code got=%b want=1", unlock_out); end
    repeat (10) @(negedge clk);
    $display("test_reset_mid_entry done");
  endtask

  task automatic test_hold();
    zero_btn = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (digit_count !== 3'd1) begin bad++; $display("FAIL hold_count got=%0d want=1", digit_count); end
    zero_btn = 1'b0;
    @(negedge clk);
    total++; if (digit_count !== 3'd1) begin bad++; $display("FAIL hold_release got=%0d want=1", digit_count); end
    $display("test_hold done");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unlock();
    test_lockout();
    test_bad_digit();
    test_program();
    test_prog_abort();
    test_reset_mid_entry();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
